// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- instruction fetch program-counter generator
//
// Produces the fetch address for the instruction memory. It steps
// sequentially by INC and can be redirected by a flush or by a resolved
// taken branch. A branch that arrives while the fetch stage cannot advance
// is parked in a one-entry pending register. That target is applied at the
// next advance.
//
// Optional feature (macro PC_GEN_BTB_EN): a direct-mapped branch target
// buffer of BTB_DEPTH entries. Each entry holds a valid bit, a tag and a
// target. The entry index is taken from the PC bits just above log2(INC),
// and the tag is the PC bits above the index. When the macro is undefined,
// no BTB storage exists, pred_taken_o is 0 and branch_pc_i is ignored.
//
// Parameters
//   ADDR_W        PC / target width in bits
//   RESET_VECTOR  first fetch address after reset
//   INC           sequential increment in bytes
//   BTB_DEPTH     BTB entries (power of two, >= 2)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stall_i           fetch-stage stall from pipeline control
//   flush_i/_pc_i     flush redirect request and target
//   branch_i          resolved taken branch from decode
//   branch_target_i   branch target
//   branch_pc_i       address of the branch instruction (BTB write key)
//   fetch_ready_i     instruction memory accepts pc_o this cycle
//   pc_o              current fetch address
//   ce_o              instruction memory chip enable
//   fetch_valid_o     pc_o is a valid fetch request
//   pred_taken_o      pc_o came from a BTB prediction
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0,
    parameter int                 INC          = 4,
    parameter int                 BTB_DEPTH    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    input  logic              fetch_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              fetch_valid_o,
    output logic              pred_taken_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pred_q, pred_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic              advance;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_target;

    // Every bit of branch_pc_i is folded in here so that the port counts as
    // used even in the build without a BTB.
    logic              unused_ok;
    assign unused_ok = ^branch_pc_i;

`ifdef PC_GEN_BTB_EN
    localparam int OFF_W = $clog2(INC);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    logic [BTB_DEPTH-1:0] btb_valid_q;
    logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_tgt_q [BTB_DEPTH];

    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic [TAG_W-1:0]     wr_tag, rd_tag;

    assign wr_idx = branch_pc_i[OFF_W +: IDX_W];
    assign wr_tag = branch_pc_i[ADDR_W-1 -: TAG_W];
    assign rd_idx = pc_q[OFF_W +: IDX_W];
    assign rd_tag = pc_q[ADDR_W-1 -: TAG_W];

    // The lookup is combinational on the current pc_o. A write in the same
    // cycle only becomes visible after the edge.
    assign btb_hit    = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    assign btb_target = btb_tgt_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
        end else if (branch_i) begin
            btb_valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target storage needs no reset because the valid bits gate it.
    always_ff @(posedge clk) begin
        if (!rst && branch_i) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= branch_target_i;
        end
    end
`else
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
`endif

    assign advance = (state_q != S_BOOT) && fetch_ready_i && !stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pred_d       = pred_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN,
            S_HOLD:  state_d = advance ? S_RUN : S_HOLD;
            default: state_d = S_BOOT;
        endcase

        if (flush_i) begin
            pc_d         = flush_pc_i;
            pred_d       = 1'b0;
            pend_valid_d = 1'b0;
        end else if (advance) begin
            // Any advance consumes the pending redirect, even when a fresher
            // branch supersedes it.
            pend_valid_d = 1'b0;
            pred_d       = 1'b0;
            if (branch_i) begin
                pc_d = branch_target_i;
            end else if (pend_valid_q) begin
                pc_d = pend_pc_q;
            end else if (btb_hit) begin
                pc_d   = btb_target;
                pred_d = 1'b1;
            end else begin
                pc_d = pc_q + ADDR_W'(INC);
            end
        end else if (branch_i) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = branch_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_VECTOR;
            pred_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pred_q       <= pred_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pc_o          = pc_q;
    assign ce_o          = (state_q != S_BOOT);
    assign fetch_valid_o = (state_q != S_BOOT);
    assign pred_taken_o  = pred_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- bench for pc_gen.
//
// A 32-bit instance is exercised with directed sequences and then random
// traffic. It is compared every cycle against a behavioural model that
// keeps the pending redirect in a queue and the BTB as a table keyed by
// word address. A 16-bit instance checks wrap-around at the top of the
// address space.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, branch, ready;
    logic [31:0] flush_pc, btgt, bpc;
    logic [31:0] pc_o;
    logic        ce_o, fv_o, pred_o;

    logic        rst16, flush16;
    logic [15:0] fpc16, pc16;
    logic        ce16, fv16, pred16;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .flush_pc_i(flush_pc), .branch_i(branch), .branch_target_i(btgt),
        .branch_pc_i(bpc), .fetch_ready_i(ready), .pc_o(pc_o), .ce_o(ce_o),
        .fetch_valid_o(fv_o), .pred_taken_o(pred_o)
    );

    pc_gen #(.ADDR_W(16)) dut16 (
        .clk(clk), .rst(rst16), .stall_i(1'b0), .flush_i(flush16),
        .flush_pc_i(fpc16), .branch_i(1'b0), .branch_target_i(16'h0),
        .branch_pc_i(16'h0), .fetch_ready_i(1'b1), .pc_o(pc16), .ce_o(ce16),
        .fetch_valid_o(fv16), .pred_taken_o(pred16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_pred;
    logic [31:0] m_pend[$];
    bit          m_bval[8];
    logic [31:0] m_bpc[8];
    logic [31:0] m_btgt[8];

    task automatic step(input bit do_check);
        bit          adv, hit;
        int          k;
        logic [31:0] n_pc;
        bit          n_pred;
        if (do_check) begin
            $display("[TB] t=%0t rst=%0b st=%0b rdy=%0b fl=%0b br=%0b pc=0x%0h pred=%0b",
                     $time, rst, stall, ready, flush, branch, pc_o, pred_o);
            check("pc_o", pc_o, m_pc);
            check("ce_o", 32'(ce_o), 32'(!m_boot));
            check("fetch_valid_o", 32'(fv_o), 32'(!m_boot));
            check("pred_taken_o", 32'(pred_o), 32'(m_pred));
        end
        n_pc   = m_pc;
        n_pred = m_pred;
        adv    = !m_boot && ready && !stall;
        k      = int'((m_pc >> 2) % 8);
`ifdef PC_GEN_BTB_EN
        hit    = m_bval[k] && ((m_bpc[k] >> 2) == (m_pc >> 2));
`else
        hit    = 1'b0;
`endif
        if (rst) begin
            n_pc   = 32'h0;
            n_pred = 1'b0;
            m_pend.delete();
            foreach (m_bval[i]) m_bval[i] = 1'b0;
        end else begin
            if (flush) begin
                n_pc   = flush_pc;
                n_pred = 1'b0;
                m_pend.delete();
            end else if (adv) begin
                n_pred = 1'b0;
                if (branch)               n_pc = btgt;
                else if (m_pend.size() > 0) n_pc = m_pend[0];
                else if (hit) begin       n_pc = m_btgt[k]; n_pred = 1'b1; end
                else                      n_pc = m_pc + 32'd4;
                m_pend.delete();
            end else if (branch) begin
                m_pend.delete();
                m_pend.push_back(btgt);
            end
            if (branch) begin
                m_bval[(bpc >> 2) % 8] = 1'b1;
                m_bpc[(bpc >> 2) % 8]  = bpc;
                m_btgt[(bpc >> 2) % 8] = btgt;
            end
        end
        @(posedge clk);
        #1;
        m_boot = rst;
        m_pc   = n_pc;
        m_pred = n_pred;
    endtask

    task automatic idle();
        stall = 0; flush = 0; branch = 0; ready = 1;
    endtask

    initial begin
        rst = 1; idle(); flush_pc = 0; btgt = 0; bpc = 0;
        rst16 = 1; flush16 = 0; fpc16 = 0;
        m_boot = 1; m_pc = 0; m_pred = 0;

        // 16-bit wrap: 0xFFFC + 4 -> 0x0000
        repeat (2) @(posedge clk);
        #1;
        rst16 = 0;
        flush16 = 1; fpc16 = 16'hFFFC;
        @(posedge clk); #1;
        flush16 = 0;
        check("w16_pc_fffc", 32'(pc16), 32'hFFFC);
        @(posedge clk); #1;
        check("w16_wrap", 32'(pc16), 32'h0000);
        check("w16_ce", 32'(ce16), 32'h1);
        $display("[TB] w16 wrap pc=0x%0h", pc16);

        // Reset release: BOOT for one cycle, then 0, 4, 8, 12
        step(0);
        rst = 0;
        check("boot_pc", pc_o, 32'h0);
        check("boot_ce", 32'(ce_o), 32'h0);
        step(1);
        step(1); step(1); step(1);
        check("seq_12", pc_o, 32'hC);
        step(1);
        // stall three cycles at 0x10
        stall = 1;
        repeat (3) step(1);
        check("stall_hold", pc_o, 32'h10);
        stall = 0;
        step(1);
        check("stall_rel", pc_o, 32'h14);
        repeat (3) step(1);
        // branch during stall at 0x20
        stall = 1; branch = 1; btgt = 32'h100;
        step(1);
        branch = 0;
        step(1);
        check("br_hold", pc_o, 32'h20);
        stall = 0;
        step(1);
        check("br_apply", pc_o, 32'h100);
        step(1);
        check("br_next", pc_o, 32'h104);
        // flush and branch together while stalled
        stall = 1; flush = 1; flush_pc = 32'h180; branch = 1; btgt = 32'h200; bpc = 32'h104;
        step(1);
        flush = 0; branch = 0;
        check("fl_pc", pc_o, 32'h180);
        check("fl_pred", 32'(pred_o), 32'h0);
        stall = 0;
        step(1);
        check("fl_pend_clr", pc_o, 32'h184);
`ifdef PC_GEN_BTB_EN
        flush = 1; flush_pc = 32'h40;
        step(1);
        flush = 0;
        branch = 1; bpc = 32'h40; btgt = 32'h300;
        step(1);
        branch = 0;
        flush = 1; flush_pc = 32'h40;
        step(1);
        flush = 0;
        step(1);
        check("btb_pc", pc_o, 32'h300);
        check("btb_pred", 32'(pred_o), 32'h1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            ready    = ($urandom_range(0, 4) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            branch   = ($urandom_range(0, 6) == 0);
            flush_pc = 32'($urandom_range(0, 63)) << 2;
            btgt     = 32'($urandom_range(0, 63)) << 2;
            bpc      = 32'($urandom_range(0, 31)) << 2;
            step(1);
        end
        rst = 0; idle();
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
